// File: rtl/led_seq_ctrl_pkg.sv
// Shared types and defaults for the LED sequence controller.
// State and opcode encodings are fixed because they are visible on the command bus and the state port.
package led_seq_pkg;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 4;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_STEP  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_RUN     = 3'd1,
    OP_PAUSE   = 3'd2,
    OP_STEP    = 3'd3,
    OP_LOAD    = 3'd4,
    OP_DIR     = 3'd5,
    OP_RESTART = 3'd6,
    OP_MODE    = 3'd7
  } op_t;

endpackage

// File: rtl/led_seq_ctrl_if.sv
// Command handshake bus between the board command source (master) and the controller (slave).
interface led_seq_ctrl_if #(
  parameter int unsigned ADDR_W = led_seq_pkg::ADDR_W
) ();
  import led_seq_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  op_t               cmd_op;
  logic [ADDR_W-1:0] cmd_arg;

  modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);

endinterface

// File: rtl/led_seq_ctrl_tick_gen.sv
// Advance-tick divider: counts 0..TICK_DIV-1 while enabled, held at zero otherwise.
module led_tick_gen #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic srst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned     CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = en && (cnt_q == LAST);

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      cnt_q <= '0;
    end else if (!en || clr || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// Run-time controller for the LED pattern ROM: command FSM, ROM address counter, LED register.
// Optional ping-pong sweep enabled by defining LED_SEQ_PINGPONG_EN.
module led_seq_ctrl #(
  parameter int unsigned TICK_DIV = 67108864,
  parameter int unsigned ADDR_W   = led_seq_pkg::ADDR_W,
  parameter int unsigned DATA_W   = led_seq_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              srst,
  led_seq_ctrl_if.slave     cmd,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] led,
  output logic              tick,
  output logic              wrap,
  output logic [1:0]        state
);
  import led_seq_pkg::*;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t            state_q, state_d;
  op_t               op;
  logic              accept, cmd_hit, advance, tick_i;
  logic [ADDR_W-1:0] addr_q, step_addr;
  logic              dir_q, step_dir, step_wrap, wrap_q;
  logic              pingpong;

  assign op     = cmd.cmd_op;
  assign accept = cmd.cmd_valid && cmd.cmd_ready;

`ifdef LED_SEQ_PINGPONG_EN
  logic pingpong_q;

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      pingpong_q <= 1'b0;
    end else if (accept && op == OP_MODE) begin
      pingpong_q <= cmd.cmd_arg[0];
    end
  end

  assign pingpong = pingpong_q;
  assign cmd_hit  = accept && (op != OP_NOP);
`else
  // MODE behaves exactly like NOP here, including not suppressing a tick advance.
  assign pingpong = 1'b0;
  assign cmd_hit  = accept && (op != OP_NOP) && (op != OP_MODE);
`endif

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_STEP) begin
      state_d = ST_PAUSE;
    end else if (accept) begin
      case (op)
        OP_RUN:     state_d = ST_RUN;
        OP_PAUSE:   if (state_q == ST_RUN) state_d = ST_PAUSE;
        OP_STEP:    state_d = ST_STEP;
        OP_RESTART: state_d = ST_IDLE;
        default:    state_d = state_q;
      endcase
    end
  end

  always_comb begin
    cmd.cmd_ready = (state_q != ST_STEP);
    state         = state_q;
  end

  // ---------------------------------------------------------------- divider
  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .srst (srst),
    .en   (state_q == ST_RUN),
    .clr  (accept && op == OP_RUN),
    .tick (tick_i)
  );

  assign tick = tick_i;

  // A command accepted in the tick cycle wins; the divider still wraps on its own.
  assign advance = (state_q == ST_STEP) || (tick_i && !cmd_hit);

  // ---------------------------------------------------------------- address
  always_comb begin
    step_dir = dir_q;
    if (dir_q == DIR_UP) begin
      step_addr = addr_q + ADDR_W'(1);
      step_wrap = (addr_q == ADDR_MAX);
      if (pingpong && addr_q == ADDR_MAX) begin
        step_addr = ADDR_MAX - ADDR_W'(1);
        step_dir  = DIR_DN;
      end
    end else begin
      step_addr = addr_q - ADDR_W'(1);
      step_wrap = (addr_q == '0);
      if (pingpong && addr_q == '0) begin
        step_addr = ADDR_W'(1);
        step_dir  = DIR_UP;
      end
    end
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      addr_q <= '0;
      dir_q  <= DIR_UP;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (advance) begin
        addr_q <= step_addr;
        dir_q  <= step_dir;
        wrap_q <= step_wrap;
      end else if (accept) begin
        case (op)
          OP_LOAD:    addr_q <= cmd.cmd_arg;
          OP_DIR:     dir_q  <= cmd.cmd_arg[0];
          OP_RESTART: addr_q <= '0;
          default:    addr_q <= addr_q;
        endcase
      end
    end
  end

  assign rom_addr = addr_q;
  assign wrap     = wrap_q;

  // ---------------------------------------------------------------- LED register
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      led <= '0;
    end else begin
      led <= rom_data;
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Scoreboard bench for led_seq_ctrl with TICK_DIV=4 and a Gray-code pattern ROM.
module tb_led_seq_ctrl;
  import led_seq_pkg::*;

  typedef enum int {F_STATE, F_ADDR, F_LED, F_TICK, F_WRAP, F_READY} fld_t;

  typedef struct {
    int         cyc;
    string      name;
    fld_t       fld;
    logic [3:0] exp;
  } exp_t;

  logic       clk = 1'b0;
  logic       srst;
  logic [3:0] rom_addr, rom_data, led;
  logic       tick, wrap;
  logic [1:0] st;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  exp_t       sb[$];

  led_seq_ctrl_if #(.ADDR_W(4)) cmd_if ();

  led_seq_ctrl #(
    .TICK_DIV (4),
    .ADDR_W   (4),
    .DATA_W   (4)
  ) dut (
    .clk      (clk),
    .srst     (srst),
    .cmd      (cmd_if.slave),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .led      (led),
    .tick     (tick),
    .wrap     (wrap),
    .state    (st)
  );

  assign rom_data = rom_addr ^ (rom_addr >> 1);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic logic [3:0] sample(input fld_t f);
    case (f)
      F_STATE: return {2'b00, st};
      F_ADDR:  return rom_addr;
      F_LED:   return led;
      F_TICK:  return {3'b000, tick};
      F_WRAP:  return {3'b000, wrap};
      F_READY: return {3'b000, cmd_if.cmd_ready};
      default: return 4'hx;
    endcase
  endfunction

  function automatic void expect_at(input int c, input fld_t f, input logic [3:0] v, input string name);
    exp_t e;
    int   i;
    e = '{cyc: c, name: name, fld: f, exp: v};
    i = 0;
    while (i < sb.size() && sb[i].cyc <= c) i++;
    sb.insert(i, e);
  endfunction

  // Monitor: compares every expectation scheduled for the current cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        if (e.cyc < cyc) begin
          n_tests++;
          n_fail++;
          $display("FAIL %s: check for cycle %0d missed", e.name, e.cyc);
        end else begin
          check(e.name, sample(e.fld), e.exp);
        end
      end
    end
  end

  task automatic send(input op_t op, input logic [3:0] arg);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_arg   = arg;
    @(posedge clk); #1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_NOP;
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int k, m;
    srst             = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_NOP;
    cmd_if.cmd_arg   = '0;
    repeat (2) @(posedge clk);
    #1 srst = 1'b0;

    k = cyc;
    expect_at(k, F_STATE, 0, "rst_state");
    expect_at(k, F_ADDR,  0, "rst_addr");
    expect_at(k, F_LED,   0, "rst_led");
    expect_at(k, F_TICK,  0, "rst_tick");
    expect_at(k, F_WRAP,  0, "rst_wrap");
    expect_at(k, F_READY, 1, "rst_ready");
    @(posedge clk); #1;

    // RUN from IDLE: ticks every 4 cycles, LED follows one cycle behind the address
    k = cyc;
    expect_at(k+1,  F_STATE, 1, "run_state");
    expect_at(k+3,  F_TICK,  0, "no_early_tick");
    expect_at(k+4,  F_TICK,  1, "tick1");
    expect_at(k+4,  F_ADDR,  0, "addr_before_tick1");
    expect_at(k+5,  F_ADDR,  1, "addr1");
    expect_at(k+5,  F_TICK,  0, "tick_one_cycle");
    expect_at(k+6,  F_LED,   4'b0001, "led_gray1");
    expect_at(k+8,  F_TICK,  1, "tick2");
    expect_at(k+9,  F_ADDR,  2, "addr2");
    expect_at(k+10, F_LED,   4'b0011, "led_gray2");
    expect_at(k+12, F_TICK,  1, "tick3");
    expect_at(k+13, F_ADDR,  3, "addr3");
    expect_at(k+13, F_WRAP,  0, "no_wrap_mid");
    expect_at(k+14, F_LED,   4'b0010, "led_gray3");
    send(OP_RUN, 4'd0);
    goto(k+14);

    // LOAD 15 mid-count keeps the divider phase; next tick wraps up to 0
    expect_at(k+15, F_ADDR, 15, "load15");
    expect_at(k+16, F_TICK, 1, "load_keeps_div");
    expect_at(k+16, F_LED,  4'b1000, "led_gray15");
    expect_at(k+17, F_ADDR, 0, "wrap_up_addr");
    expect_at(k+17, F_WRAP, 1, "wrap_up");
    expect_at(k+18, F_WRAP, 0, "wrap_up_pulse");
    expect_at(k+18, F_LED,  0, "led_gray0");
    send(OP_LOAD, 4'd15);
    goto(k+18);

    // DIR down then RUN (clears divider) -> 0 wraps down to 15
    expect_at(k+20, F_TICK,  0, "run_clears_div");
    expect_at(k+23, F_TICK,  1, "tick_after_rerun");
    expect_at(k+23, F_ADDR,  0, "addr_before_dn");
    expect_at(k+24, F_ADDR,  15, "wrap_dn_addr");
    expect_at(k+24, F_WRAP,  1, "wrap_dn");
    expect_at(k+24, F_STATE, 1, "still_run");
    expect_at(k+25, F_WRAP,  0, "wrap_dn_pulse");
    send(OP_DIR, 4'd1);
    send(OP_RUN, 4'd0);
    goto(k+27);

    // PAUSE on the tick cycle: tick still shown, no advance
    expect_at(k+27, F_TICK,  1, "tick_with_pause");
    expect_at(k+28, F_ADDR,  15, "pause_no_adv");
    expect_at(k+28, F_STATE, 2, "pause_state");
    expect_at(k+28, F_WRAP,  0, "pause_no_wrap");
    send(OP_PAUSE, 4'd0);
    goto(k+29);

    // STEP held valid for three cycles: accepted twice, one cycle apart
    expect_at(k+30, F_STATE, 3, "step_state");
    expect_at(k+30, F_READY, 0, "step_not_ready");
    expect_at(k+30, F_ADDR,  15, "step_addr_hold");
    expect_at(k+31, F_ADDR,  14, "step_adv");
    expect_at(k+31, F_STATE, 2, "step_to_pause");
    expect_at(k+31, F_READY, 1, "ready_after_step");
    expect_at(k+32, F_STATE, 3, "step_again");
    expect_at(k+32, F_ADDR,  14, "step_again_hold");
    expect_at(k+33, F_ADDR,  13, "step_adv2");
    expect_at(k+33, F_STATE, 2, "step_to_pause2");
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = OP_STEP;
    repeat (3) begin
      @(posedge clk); #1;
    end
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_NOP;
    goto(k+34);

    // RUN from PAUSE: first tick 4 cycles after acceptance
    expect_at(k+37, F_TICK, 0, "resume_no_early");
    expect_at(k+38, F_TICK, 1, "resume_tick");
    expect_at(k+38, F_ADDR, 13, "resume_addr_hold");
    expect_at(k+39, F_ADDR, 12, "resume_adv");
    expect_at(k+40, F_LED,  4'b1010, "led_gray12");
    send(OP_RUN, 4'd0);
    goto(k+40);

    // Asynchronous reset between edges while running at address 9
    send(OP_LOAD, 4'd9);
    check("pre_rst_addr",  rom_addr, 4'd9);
    check("pre_rst_state", {2'b00, st}, 4'd1);
    check("pre_rst_led",   led, 4'b1010);
    #3 srst = 1'b1;
    #1;
    check("arst_state", {2'b00, st}, 4'd0);
    check("arst_addr",  rom_addr, 4'd0);
    check("arst_led",   led, 4'd0);
    check("arst_tick",  {3'b000, tick}, 4'd0);
    check("arst_wrap",  {3'b000, wrap}, 4'd0);
    check("arst_ready", {3'b000, cmd_if.cmd_ready}, 4'd1);
    @(posedge clk); #1;
    srst = 1'b0;

    // MODE 1, LOAD 14, RUN: ping-pong reverses at 15, otherwise wraps
    m = cyc;
    expect_at(m+2,  F_ADDR,  14, "pp_load14");
    expect_at(m+3,  F_STATE, 1, "pp_run");
    expect_at(m+6,  F_TICK,  1, "pp_tick1");
    expect_at(m+7,  F_ADDR,  15, "pp_addr15");
    expect_at(m+7,  F_WRAP,  0, "pp_no_wrap15");
    expect_at(m+10, F_TICK,  1, "pp_tick2");
`ifdef LED_SEQ_PINGPONG_EN
    expect_at(m+11, F_ADDR,  14, "pp_turn_addr");
    expect_at(m+11, F_WRAP,  1, "pp_turn_wrap");
    expect_at(m+15, F_ADDR,  13, "pp_down_addr");
    expect_at(m+15, F_WRAP,  0, "pp_down_nowrap");
`else
    expect_at(m+11, F_ADDR,  0, "nopp_wrap_addr");
    expect_at(m+11, F_WRAP,  1, "nopp_wrap");
    expect_at(m+15, F_ADDR,  1, "nopp_up_addr");
    expect_at(m+15, F_WRAP,  0, "nopp_nowrap");
`endif
    send(OP_MODE, 4'd1);
    send(OP_LOAD, 4'd14);
    send(OP_RUN,  4'd0);
    goto(m+15);

    // RESTART returns to IDLE at address 0
    expect_at(m+16, F_STATE, 0, "restart_state");
    expect_at(m+16, F_ADDR,  0, "restart_addr");
    send(OP_RESTART, 4'd0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      @(negedge clk); #1;
    end
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s: check for cycle %0d never reached", e.name, e.cyc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
